// File: rtl/tlb_mmu_multiport.sv
// MIPS32 joint TLB with NPORTS parallel lookup ports, TLBP/TLBR/TLBWI/TLBWR
// maintenance and the CP0 Random counter. Lookup results are registered.
module tlb_mmu_multiport #(
   parameter int ENTRIES = 32,
   parameter int NPORTS  = 2,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NPORTS-1:0]    lk_req,
   input  logic [NPORTS-1:0]    lk_wr,
   input  logic [32*NPORTS-1:0] lk_vaddr,
   input  logic [7:0]           asid,
   output logic [NPORTS-1:0]    lk_done,
   output logic [32*NPORTS-1:0] lk_paddr,
   output logic [3*NPORTS-1:0]  lk_exc,
   output logic [NPORTS-1:0]    lk_cached,
   input  logic                 op_valid,
   input  logic [1:0]           op_code,
   input  logic [IDX_W-1:0]     op_index,
   input  logic [31:0]          op_entryhi,
   input  logic [31:0]          op_entrylo0,
   input  logic [31:0]          op_entrylo1,
   input  logic [IDX_W-1:0]     wired,
   output logic                 op_done,
   output logic [31:0]          res_index,
   output logic [31:0]          res_entryhi,
   output logic [31:0]          res_entrylo0,
   output logic [31:0]          res_entrylo1,
   output logic [IDX_W-1:0]     random
);

   localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(ENTRIES - 1);

   localparam logic [2:0] EXC_NONE      = 3'd0;
   localparam logic [2:0] EXC_REFILL_L  = 3'd1;
   localparam logic [2:0] EXC_REFILL_S  = 3'd2;
   localparam logic [2:0] EXC_INVALID_L = 3'd3;
   localparam logic [2:0] EXC_INVALID_S = 3'd4;
   localparam logic [2:0] EXC_MODIFIED  = 3'd5;

   localparam logic [1:0] OP_TLBP = 2'd0;
   localparam logic [1:0] OP_TLBR = 2'd1;

   // Page halves are held as {PFN[19:0], C[2:0], D, V}, i.e. EntryLo[25:1].
   logic [18:0] e_vpn2 [ENTRIES];
   logic [7:0]  e_asid [ENTRIES];
   logic        e_g    [ENTRIES];
   logic [24:0] e_lo0  [ENTRIES];
   logic [24:0] e_lo1  [ENTRIES];

   logic [31:0]       nxt_paddr [NPORTS];
   logic [2:0]        nxt_exc   [NPORTS];
   logic [NPORTS-1:0] nxt_cached;

   logic             p_hit;
   logic [IDX_W-1:0] p_idx;
   logic [IDX_W-1:0] widx;

   always_comb begin
      logic [31:0]      va;
      logic             hit;
      logic [IDX_W-1:0] sel;
      logic [24:0]      lo;
      va         = '0;
      hit        = 1'b0;
      sel        = '0;
      lo         = '0;
      nxt_cached = '0;
      for (int unsigned p = 0; p < NPORTS; p++) begin
         va  = lk_vaddr[32*p +: 32];
         hit = 1'b0;
         sel = '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!hit && e_vpn2[i] == va[31:13] && (e_g[i] || e_asid[i] == asid)) begin
               hit = 1'b1;
               sel = IDX_W'(i);
            end
         end
         lo           = va[12] ? e_lo1[sel] : e_lo0[sel];
         nxt_paddr[p] = '0;
         nxt_exc[p]   = EXC_NONE;
         if (va[31:30] == 2'b10) begin
            // kseg0/kseg1: both map onto the low 512 MB; only kseg0 is cached
            nxt_paddr[p]  = {3'b000, va[28:0]};
            nxt_cached[p] = ~va[29];
         end else if (!hit) begin
            nxt_exc[p] = lk_wr[p] ? EXC_REFILL_S : EXC_REFILL_L;
         end else if (!lo[0]) begin
            nxt_exc[p] = lk_wr[p] ? EXC_INVALID_S : EXC_INVALID_L;
         end else if (lk_wr[p] && !lo[1]) begin
            nxt_exc[p] = EXC_MODIFIED;
         end else begin
            nxt_paddr[p]  = {lo[24:5], va[11:0]};
            nxt_cached[p] = (lo[4:2] == 3'd3);
         end
      end
   end

   always_comb begin
      p_hit = 1'b0;
      p_idx = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (!p_hit && e_vpn2[i] == op_entryhi[31:13] &&
             (e_g[i] || e_asid[i] == op_entryhi[7:0])) begin
            p_hit = 1'b1;
            p_idx = IDX_W'(i);
         end
      end
   end

   assign widx = op_code[0] ? random : op_index;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            e_vpn2[i] <= '0;
            e_asid[i] <= '0;
            e_g[i]    <= 1'b0;
            e_lo0[i]  <= '0;
            e_lo1[i]  <= '0;
         end
         random       <= RAND_MAX;
         lk_done      <= '0;
         lk_paddr     <= '0;
         lk_exc       <= '0;
         lk_cached    <= '0;
         op_done      <= 1'b0;
         res_index    <= '0;
         res_entryhi  <= '0;
         res_entrylo0 <= '0;
         res_entrylo1 <= '0;
      end else begin
         random  <= (random <= wired) ? RAND_MAX : random - 1'b1;
         op_done <= op_valid;
         lk_done <= lk_req & {NPORTS{~op_valid}};
         for (int unsigned p = 0; p < NPORTS; p++) begin
            if (lk_req[p] && !op_valid) begin
               lk_paddr[32*p +: 32] <= nxt_paddr[p];
               lk_exc[3*p +: 3]     <= nxt_exc[p];
               lk_cached[p]         <= nxt_cached[p];
            end
         end
         if (op_valid) begin
            if (op_code == OP_TLBP) begin
               res_index <= p_hit ? {{(32-IDX_W){1'b0}}, p_idx} : 32'h8000_0000;
            end else if (op_code == OP_TLBR) begin
               res_entryhi  <= {e_vpn2[op_index], 5'b0, e_asid[op_index]};
               res_entrylo0 <= {6'b0, e_lo0[op_index], e_g[op_index]};
               res_entrylo1 <= {6'b0, e_lo1[op_index], e_g[op_index]};
            end else begin
               e_vpn2[widx] <= op_entryhi[31:13];
               e_asid[widx] <= op_entryhi[7:0];
               e_g[widx]    <= op_entrylo0[0] & op_entrylo1[0];
               e_lo0[widx]  <= op_entrylo0[25:1];
               e_lo1[widx]  <= op_entrylo1[25:1];
            end
         end
      end
   end

endmodule
